// File: rtl/freq_div.sv
// freq_div: integer clock divider.
//   N = CLK_FREQ_HZ / OUT_FREQ_HZ (floor). clk_out has a period of exactly N
//   clk cycles: high for ceil(N/2) cycles, then low for floor(N/2) cycles.
//   After reset release, clk_out rises on the first active clk edge.
// Optional feature macro: FREQ_DIV_TICK_EN adds the 'tick' output. tick is a
//   one-cycle pulse that coincides with every clk_out rising edge.
// Reset: asynchronous, active-low (rst_n). It clears the counter and all outputs.
`timescale 1ns/1ps

module freq_div #(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int OUT_FREQ_HZ = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
`ifdef FREQ_DIV_TICK_EN
  ,
  output logic tick
`endif
);

  // Division ratio. The guard keeps elaboration from dividing by zero, so
  // that the range check below can report the error.
  localparam int N    = (OUT_FREQ_HZ == 0) ? 0 : (CLK_FREQ_HZ / OUT_FREQ_HZ);
  localparam int HIGH = N - (N / 2);
  localparam int CW   = (N < 2) ? 1 : $clog2(N);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(HIGH);

  // Reject ratios that cannot produce a toggling output.
  generate
    if ((N < 2) || (OUT_FREQ_HZ == 0)) begin : g_bad_ratio
      $error("freq_div: division ratio N=%0d is invalid (needs N >= 2 and OUT_FREQ_HZ > 0)", N);
    end
  endgenerate

  // cnt is the position within the output period. clk_out and tick are
  // registered from the current cnt, so they show the phase that cnt held
  // one cycle earlier. Reset leaves cnt at 0, so the first edge after
  // release loads position 0 into clk_out. That makes the first rising edge
  // land on that clk edge, and the following full high phase is intact.
  logic [CW-1:0] cnt;

  // Period counter: counts 0..N-1, then wraps to 0 with no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Divided clock, driven straight from a flop: high for the first ceil(N/2) positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out <= 1'b0;
    end else begin
      clk_out <= (cnt < CNT_HIGH);
    end
  end

`ifdef FREQ_DIV_TICK_EN
  // Period pulse, aligned with the clk_out rise (position 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else begin
      tick <= (cnt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_freq_div.sv
// tb_freq_div: scoreboard bench for freq_div.
// It runs three instances side by side: N=5 (10/2), N=4 (8/2) and N=13 (150/11).
// Reset is asserted and released at random points between clock edges.
`timescale 1ns/1ps

module tb_freq_div;

  localparam int N_A = 5;
  localparam int N_B = 4;
  localparam int N_C = 13;

  logic clk;
  logic rst_n;
  logic co_a, co_b, co_c;
`ifdef FREQ_DIV_TICK_EN
  logic tk_a, tk_b, tk_c;
`endif

  int checks   = 0;
  int failures = 0;

  // Each entry packs {tick_c, tick_b, tick_a, clk_out_c, clk_out_b, clk_out_a}.
  logic [5:0] exp_q[$];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  freq_div #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(2)) u_a (
    .clk(clk), .rst_n(rst_n), .clk_out(co_a)
`ifdef FREQ_DIV_TICK_EN
    , .tick(tk_a)
`endif
  );

  freq_div #(.CLK_FREQ_HZ(8), .OUT_FREQ_HZ(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clk_out(co_b)
`ifdef FREQ_DIV_TICK_EN
    , .tick(tk_b)
`endif
  );

  freq_div #(.CLK_FREQ_HZ(150), .OUT_FREQ_HZ(11)) u_c (
    .clk(clk), .rst_n(rst_n), .clk_out(co_c)
`ifdef FREQ_DIV_TICK_EN
    , .tick(tk_c)
`endif
  );

  // Current DUT outputs in scoreboard layout. When tick is absent, the tick
  // bits are 0 and only the clk_out bits carry information.
  function automatic logic [5:0] actual_bits();
`ifdef FREQ_DIV_TICK_EN
    return {tk_c, tk_b, tk_a, co_c, co_b, co_a};
`else
    return {3'b000, co_c, co_b, co_a};
`endif
  endfunction

  // ---------------- reference model ----------------
  // k counts clk edges since reset release (k = 1 on the first edge).
  // Output period p = (k-1) mod n. The output is high for p < ceil(n/2),
  // and the pulse fires at p == 0.
  function automatic logic model_out(int k, int n);
    if (k < 1) return 1'b0;
    return (((k - 1) % n) < ((n + 1) / 2));
  endfunction

  function automatic logic model_tick(int k, int n);
`ifdef FREQ_DIV_TICK_EN
    if (k < 1) return 1'b0;
    return (((k - 1) % n) == 0);
`else
    return 1'b0;
`endif
  endfunction

  int k_model = 0;

  // At each active edge, advance the model and queue the expected outputs.
  always @(posedge clk) begin
    if (!rst_n) k_model = 0;
    else        k_model = k_model + 1;
    exp_q.push_back({model_tick(k_model, N_C), model_tick(k_model, N_B), model_tick(k_model, N_A),
                     model_out(k_model, N_C),  model_out(k_model, N_B),  model_out(k_model, N_A)});
  end

  // ---------------- monitor ----------------
  // On the opposite edge, pop one expectation and compare it with the DUTs.
  always @(negedge clk) begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = actual_bits();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t k=%0d actual=%b expected=%b", $time, k_model, act_v, exp_v);
      end
    end
  end

  // Direct check for asynchronous reset behaviour: all outputs must read 0.
  task automatic check_zero(input string name);
    logic [5:0] act_v;
    act_v = actual_bits();
    checks++;
    if (act_v !== 6'b000000) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b expected=000000", name, $time, act_v);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("reset_initial");

    // First release, followed by a long run: covers 10 periods of N=4 and many of N=5/N=13.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_zero("release_hold");
    repeat (60) @(posedge clk);

    // Random segments. Reset is asserted between edges at a random phase of
    // the period, then released between edges after a random hold time.
    for (int s = 0; s < 25; s++) begin
      repeat ($urandom_range(3, 40)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1 check_zero("async_reset");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3));
      rst_n = 1'b1;
      #1 check_zero("release_hold");
    end

    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_div.md
FREQ_DIV -- requirements
Module: freq_div

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 27_000_000, input clock frequency in Hz.
REQ-002 Parameter OUT_FREQ_HZ, default 1_000, target output frequency in Hz.
REQ-003 Derived constant N = CLK_FREQ_HZ / OUT_FREQ_HZ (integer floor) SHALL be the division ratio; counter width = $clog2(N).
REQ-004 clk  input  1  single clock, rising-edge active, 27 MHz nominal.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clk_out  output  1  divided clock, registered, glitch-free.
REQ-007 tick  output  1  one-cycle pulse per output period; present only with FREQ_DIV_TICK_EN.

Function
REQ-008 Internal counter cnt SHALL count 0..N-1 on every rising clk edge, then wrap to 0.
REQ-009 clk_out SHALL be high while cnt < N - N/2 and low otherwise; high phase = ceil(N/2) cycles, low phase = floor(N/2) cycles.
REQ-010 For even N, duty cycle SHALL be exactly 50%; for odd N, high phase SHALL exceed low phase by one clk cycle.
REQ-011 clk_out SHALL be driven directly from a flip-flop, never from combinational logic.
REQ-012 Output period SHALL be exactly N clk cycles, with no drift and no skipped or extra cycles at wrap-around.
REQ-013 The first clk_out rising edge after reset release SHALL occur on the first active clk edge after rst_n goes high.
REQ-014 Elaboration SHALL fail via $error when N < 2 or OUT_FREQ_HZ = 0.
REQ-015 With defaults (N = 27_000), clk_out SHALL be high for 13_500 cycles and low for 13_500 cycles (1 kHz).

Reset
REQ-016 rst_n low SHALL immediately clear cnt to 0, clk_out to 0 and tick to 0, independent of clk.
REQ-017 Reset asserted mid-period SHALL abort the current period; counting SHALL restart from cnt = 0 after release.
REQ-018 Release of rst_n SHALL be sampled on clk; no output SHALL change between the release and the next rising clk edge.

Configuration
REQ-019 Macro FREQ_DIV_TICK_EN SHALL control inclusion of the tick output.
REQ-020 When FREQ_DIV_TICK_EN is defined, tick SHALL be high for exactly one clk cycle, registered, coincident with every clk_out rising edge (cnt = 0).
REQ-021 When FREQ_DIV_TICK_EN is undefined, the tick port and its logic SHALL be absent; clk_out behaviour SHALL be identical in both builds.

Verification
REQ-022 Parameters 10/2 (N = 5), reset released -> clk_out pattern 1,1,1,0,0 repeating, period 5 cycles.
REQ-023 Parameters 8/2 (N = 4) -> clk_out high 2 cycles, low 2 cycles, 50% duty over 10 periods.
REQ-024 Defaults, 27 MHz clk (37 ns period), run 3 ms -> 3 full clk_out periods of 1.0 ms each, with edges every 13_500 clk cycles.
REQ-025 Assert rst_n low mid-high-phase, between clk edges -> clk_out = 0 immediately; after release, a full high phase of ceil(N/2) cycles.
REQ-026 With FREQ_DIV_TICK_EN, N = 5 -> tick high exactly 1 cycle every 5 cycles, aligned to the clk_out rise; no tick during reset.
REQ-027 Parameters giving N = 1 -> elaboration error reported.
